// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Performs a WIDTH-bit add over NIB = WIDTH/4 clock cycles by pushing one
// nibble per cycle, LSB first, through a single shared 4-bit carry-select
// slice. Operands arrive on a valid/ready handshake and the result leaves on
// another, so several wide adds can share one narrow slice at the cost of
// latency.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   producer has a, b, cin valid
//   in_ready   block can take operands (only while IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   out_valid  sum/cout/ovf are valid and held until out_ready
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   busy       high while an add is in RUN or DONE
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [IDXW+1:0]   bit_base;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        s0;
    logic [4:0]        s1;
    logic [4:0]        slice;
    logic              carry_into_msb;

    // Operands can only be taken while idle, so in_ready is a pure state
    // decode and can never coincide with out_valid.
    assign in_ready = (state == IDLE);

    // The shared slice: both carry-in cases are computed in parallel and the
    // registered carry picks one. Bit 3's incoming carry is recovered from
    // the sum bit itself (s3 = a3 ^ b3 ^ c3), which is what the overflow
    // flag of the top nibble needs.
    always_comb begin
        bit_base       = {idx, 2'b00};
        a_nib          = op_a[bit_base +: 4];
        b_nib          = op_b[bit_base +: 4];
        s0             = {1'b0, a_nib} + {1'b0, b_nib};
        s1             = s0 + 5'd1;
        slice          = carry ? s1 : s0;
        carry_into_msb = a_nib[3] ^ b_nib[3] ^ slice[3];
    end

    // Sequencer: IDLE accepts operands, RUN walks the nibbles LSB first
    // writing one result nibble per cycle, DONE holds the result until the
    // consumer takes it. Reset wins over every transition, discarding any
    // in-flight add. Nibbles not yet written in RUN keep their old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[bit_base +: 4] <= slice[3:0];
                    carry              <= slice[4];
                    idx                <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= slice[4];
                        ovf       <= carry_into_msb ^ slice[4];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Directed bench for the 16-bit nibble-serial adder. Every expected sum,
// carry and overflow is hand-computed in the call sites below. Inputs are
// driven and outputs sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks_total  = 0;
    int checks_passed = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            checks_passed++;
    endtask

    // Waits (bounded) for in_ready on a falling edge, presents operands and
    // returns just after the rising edge that accepts them
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Full transaction: accept, wait for the result, check it, and optionally
    // hand it to the consumer straight away
    task automatic runAdd(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic cv,
                          input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input bit consume);
        int lat;
        applyStimulus(av, bv, cv);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
            checkOutput({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
            checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        end
    endtask

    // Directed scenario sequence
    initial begin
        int ov_cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'hDEAD;
        b         = 16'hBEEF;
        cin       = 1'b1;

        // Reset with in_valid high: nothing may be accepted
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        runAdd("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        runAdd("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        runAdd("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        runAdd("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        runAdd("cin_only",16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);

        // Backpressure: hold the result for 5 cycles while in_valid pulses
        runAdd("bp", 16'h2222, 16'h1111, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a        = 16'h0F0F + 16'(i);
            b        = 16'h7070;
            cin      = 1'b1;
            in_valid = (i % 2) == 0;
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_sum", 32'(sum), 32'h3333);
            checkOutput("bp_hold_cout", 32'(cout), 32'd0);
            checkOutput("bp_hold_ovf", 32'(ovf), 32'd0);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("bp_no_phantom_busy", 32'(busy), 32'd0);

        // Reset while RUN is on nibble 2 of 0xABCD+0x1111
        applyStimulus(16'hABCD, 16'h1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sum", 32'(sum), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        checkOutput("midrst_no_pulse", 32'(ov_cnt), 32'd0);
        runAdd("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
